alu_issue_ctrl: RTL and testbench

// - Producer/consumer end of the 64-bit ALU interface in the RISC-V datapath.
// - Decodes aluOp/funct3/funct7[30] into the 4-bit aluControl code.
// - Registers operands into the ALU and captures aluResult/zero into a result stage.
// - Two-stage valid/ready pipeline; throughput of 1 op/cycle; stalls cleanly on backpressure.

---
 rtl/alu_pkg.sv | 73 +++++++
 rtl/alu_decode.sv | 37 +++
 rtl/alu_issue_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : alu_pkg
// Purpose : Shared encodings for the ALU issue path: 4-bit ALU operation
//           codes, 2-bit aluOp classes from the main decoder, and the funct3
//           values that the funct-decode path recognises.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package alu_pkg;

    // ALU operation codes. Only these four are ever driven on aluControl.
    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;

    // aluOp classes produced by the main control decoder.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;  // loads / stores
    localparam logic [1:0] ALUOP_SUB   = 2'b01;  // beq compare
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;  // R/I-type, decode funct3
    localparam logic [1:0] ALUOP_ILL   = 2'b11;  // never legal

    // funct3 values understood by the funct-decode path.
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // Decoder result bundle.
    typedef struct packed {
        logic [3:0] ctrl;
        logic       illegal;
    } alu_dec_t;

    // Reference decode used by the combinational decoder. An unrecognised
    // encoding falls back to ADD so the ALU always sees a defined code, and
    // the illegal flag tells downstream logic to discard the result.
    function automatic alu_dec_t alu_decode_fn(
        input logic [1:0] alu_op,
        input logic [2:0] funct3,
        input logic       funct7b30,
        input logic       alu_src
    );
        alu_dec_t dec;
        dec.ctrl    = ALU_ADD;
        dec.illegal = 1'b0;
        case (alu_op)
            ALUOP_ADD: dec.ctrl = ALU_ADD;
            ALUOP_SUB: dec.ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // SUB only for the register form; an immediate with
                    // bit 30 set is ADDI whose immediate happens to have it.
                    F3_ADD_SUB: dec.ctrl = (funct7b30 && !alu_src) ? ALU_SUB : ALU_ADD;
                    F3_AND:     dec.ctrl = ALU_AND;
                    F3_OR:      dec.ctrl = ALU_OR;
                    default: begin
                        dec.ctrl    = ALU_ADD;
                        dec.illegal = 1'b1;
                    end
                endcase
            end
            default: begin
                dec.ctrl    = ALU_ADD;
                dec.illegal = 1'b1;
            end
        endcase
        return dec;
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_decode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : alu_decode
// Purpose : Combinational ALU control decoder. Maps the main-decoder aluOp
//           class plus instruction funct3 / bit 30 / operand source onto a
//           4-bit ALU code and an illegal-operation flag.
// Ports   : i_alu_op[1:0]     aluOp class
//           i_funct3[2:0]     instruction funct3
//           i_funct7b30       instruction bit 30
//           i_alu_src         1: second operand is the immediate
//           o_alu_control[3:0] ALU operation code
//           o_illegal         encoding not supported
// Rev     : 1.0  initial release
// ============================================================================
module alu_decode
    import alu_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b30,
    input  logic       i_alu_src,
    output logic [3:0] o_alu_control,
    output logic       o_illegal
);

    alu_dec_t w_dec;

    always_comb begin
        w_dec = alu_decode_fn(i_alu_op, i_funct3, i_funct7b30, i_alu_src);
    end

    assign o_alu_control = w_dec.ctrl;
    assign o_illegal     = w_dec.illegal;

endmodule : alu_decode
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : alu_issue_ctrl
// Purpose : Issue/capture controller around a combinational 64-bit ALU.
//           Stage 1 registers the operands and the decoded ALU code that feed
//           the ALU; stage 2 captures the ALU result, zero-derived branch
//           outcome and illegal flag. Valid/ready handshaking on both sides
//           sustains one operation per cycle and freezes cleanly under
//           backpressure.
// Ports   : clk, reset            clock, synchronous active-high reset
//           in_valid / in_ready   request handshake
//           aluOp, funct3, funct7b30, aluSrc, branch   instruction control
//           rs1, rs2, imm         operands
//           aluX, aluY, aluControl   registered ALU inputs
//           aluResult, zero       ALU outputs (combinational, from aluX/aluY)
//           out_valid / out_ready result handshake
//           result, branchTaken, illegal   captured result stage
//           issued_cnt, illegal_cnt        accepted / accepted-illegal counts
// Rev     : 1.0  initial release
// ============================================================================
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    // request side
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       aluOp,
    input  logic [2:0]       funct3,
    input  logic             funct7b30,
    input  logic             aluSrc,
    input  logic             branch,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    input  logic [XLEN-1:0]  imm,
    // ALU interface
    output logic [XLEN-1:0]  aluX,
    output logic [XLEN-1:0]  aluY,
    output logic [3:0]       aluControl,
    input  logic [XLEN-1:0]  aluResult,
    input  logic             zero,
    // result side
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic             branchTaken,
    output logic             illegal,
    // statistics
    output logic [CNT_W-1:0] issued_cnt,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Decode of the incoming request
    // ------------------------------------------------------------------
    logic [3:0] w_dec_ctrl;
    logic       w_dec_illegal;

    alu_decode u_alu_decode (
        .i_alu_op      (aluOp),
        .i_funct3      (funct3),
        .i_funct7b30   (funct7b30),
        .i_alu_src     (aluSrc),
        .o_alu_control (w_dec_ctrl),
        .o_illegal     (w_dec_illegal)
    );

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    // Stage 1: operands and control presented to the ALU
    logic             r_s1_valid_q,    w_s1_valid_d;
    logic [XLEN-1:0]  r_alu_x_q,       w_alu_x_d;
    logic [XLEN-1:0]  r_alu_y_q,       w_alu_y_d;
    logic [3:0]       r_alu_ctrl_q,    w_alu_ctrl_d;
    logic             r_s1_branch_q,   w_s1_branch_d;
    logic             r_s1_illegal_q,  w_s1_illegal_d;
    // Stage 2: captured ALU outcome
    logic             r_out_valid_q,   w_out_valid_d;
    logic [XLEN-1:0]  r_result_q,      w_result_d;
    logic             r_br_taken_q,    w_br_taken_d;
    logic             r_s2_illegal_q,  w_s2_illegal_d;
    // Counters
    logic [CNT_W-1:0] r_issued_cnt_q,  w_issued_cnt_d;
    logic [CNT_W-1:0] r_illegal_cnt_q, w_illegal_cnt_d;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic w_s2_take;   // stage 2 can load this edge
    logic w_s1_adv;    // stage 1 content moves into stage 2 this edge
    logic w_in_ready;
    logic w_accept;    // input handshake completes this edge

    // in_ready deliberately has no in_valid term so the producer can
    // present a request without forming a combinational loop.
    assign w_s2_take  = !r_out_valid_q || out_ready;
    assign w_s1_adv   = r_s1_valid_q && w_s2_take;
    assign w_in_ready = !r_s1_valid_q || w_s2_take;
    assign w_accept   = in_valid && w_in_ready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // default: every register holds, which gives bit-stable outputs
        // during a stall
        w_s1_valid_d    = r_s1_valid_q;
        w_alu_x_d       = r_alu_x_q;
        w_alu_y_d       = r_alu_y_q;
        w_alu_ctrl_d    = r_alu_ctrl_q;
        w_s1_branch_d   = r_s1_branch_q;
        w_s1_illegal_d  = r_s1_illegal_q;
        w_out_valid_d   = r_out_valid_q;
        w_result_d      = r_result_q;
        w_br_taken_d    = r_br_taken_q;
        w_s2_illegal_d  = r_s2_illegal_q;
        w_issued_cnt_d  = r_issued_cnt_q;
        w_illegal_cnt_d = r_illegal_cnt_q;

        // Stage 1: whenever it is free or draining, its next occupancy is
        // simply whether a request is being presented.
        if (w_in_ready) begin
            w_s1_valid_d = in_valid;
        end
        if (w_accept) begin
            w_alu_x_d      = rs1;
            w_alu_y_d      = aluSrc ? imm : rs2;
            w_alu_ctrl_d   = w_dec_ctrl;
            w_s1_branch_d  = branch;
            w_s1_illegal_d = w_dec_illegal;
        end

        // Stage 2: reload from stage 1 (possibly to empty). Payload only
        // updates on a real transfer so result keeps its last value when
        // the stage drains.
        if (w_s2_take) begin
            w_out_valid_d = r_s1_valid_q;
        end
        if (w_s1_adv) begin
            w_result_d     = aluResult;
            w_br_taken_d   = r_s1_branch_q & zero;
            w_s2_illegal_d = r_s1_illegal_q;
        end

        // Counters wrap naturally at 2^CNT_W.
        if (w_accept) begin
            w_issued_cnt_d = r_issued_cnt_q + c_cnt_one;
            if (w_dec_illegal) begin
                w_illegal_cnt_d = r_illegal_cnt_q + c_cnt_one;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            // in_valid is ignored here; in-flight ops are discarded
            r_s1_valid_q    <= 1'b0;
            r_alu_x_q       <= '0;
            r_alu_y_q       <= '0;
            r_alu_ctrl_q    <= ALU_AND;
            r_s1_branch_q   <= 1'b0;
            r_s1_illegal_q  <= 1'b0;
            r_out_valid_q   <= 1'b0;
            r_result_q      <= '0;
            r_br_taken_q    <= 1'b0;
            r_s2_illegal_q  <= 1'b0;
            r_issued_cnt_q  <= '0;
            r_illegal_cnt_q <= '0;
        end else begin
            r_s1_valid_q    <= w_s1_valid_d;
            r_alu_x_q       <= w_alu_x_d;
            r_alu_y_q       <= w_alu_y_d;
            r_alu_ctrl_q    <= w_alu_ctrl_d;
            r_s1_branch_q   <= w_s1_branch_d;
            r_s1_illegal_q  <= w_s1_illegal_d;
            r_out_valid_q   <= w_out_valid_d;
            r_result_q      <= w_result_d;
            r_br_taken_q    <= w_br_taken_d;
            r_s2_illegal_q  <= w_s2_illegal_d;
            r_issued_cnt_q  <= w_issued_cnt_d;
            r_illegal_cnt_q <= w_illegal_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready    = w_in_ready;
    assign aluX        = r_alu_x_q;
    assign aluY        = r_alu_y_q;
    assign aluControl  = r_alu_ctrl_q;
    assign out_valid   = r_out_valid_q;
    assign result      = r_result_q;
    assign branchTaken = r_br_taken_q;
    assign illegal     = r_s2_illegal_q;
    assign issued_cnt  = r_issued_cnt_q;
    assign illegal_cnt = r_illegal_cnt_q;

endmodule : alu_issue_ctrl
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_alu_issue_ctrl
// Purpose : Self-checking bench for alu_issue_ctrl wired to a behavioural
//           64-bit ALU. Expected results are pushed to a scoreboard queue on
//           each input handshake and compared on each output handshake;
//           directed checks cover latency, stalls, counters and reset.
// Rev     : 1.0  initial release
// ============================================================================
module tb_alu_issue_ctrl;

    localparam int XLEN  = 64;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       aluOp;
    logic [2:0]       funct3;
    logic             funct7b30;
    logic             aluSrc;
    logic             branch;
    logic [XLEN-1:0]  rs1, rs2, imm;
    logic [XLEN-1:0]  aluX, aluY;
    logic [3:0]       aluControl;
    logic [XLEN-1:0]  aluResult;
    logic             zero;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  result;
    logic             branchTaken;
    logic             illegal;
    logic [CNT_W-1:0] issued_cnt;
    logic [CNT_W-1:0] illegal_cnt;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .aluOp(aluOp), .funct3(funct3), .funct7b30(funct7b30),
        .aluSrc(aluSrc), .branch(branch),
        .rs1(rs1), .rs2(rs2), .imm(imm),
        .aluX(aluX), .aluY(aluY), .aluControl(aluControl),
        .aluResult(aluResult), .zero(zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .branchTaken(branchTaken), .illegal(illegal),
        .issued_cnt(issued_cnt), .illegal_cnt(illegal_cnt)
    );

    // ---------------- behavioural ALU and reference model ----------------
    function automatic logic [63:0] alu_f(input logic [63:0] x, y, input logic [3:0] c);
        case (c)
            4'd0:    return x & y;
            4'd1:    return x | y;
            4'd2:    return x + y;
            4'd6:    return x - y;
            default: return 64'h0;
        endcase
    endfunction

    always_comb begin
        aluResult = alu_f(aluX, aluY, aluControl);
        zero      = (aluResult == 64'h0);
    end

    function automatic logic [3:0] m_ctrl(input logic [1:0] op, input logic [2:0] f3,
                                          input logic b30, input logic src);
        if (op == 2'b00) return 4'd2;
        if (op == 2'b01) return 4'd6;
        if (op == 2'b10) begin
            if (f3 == 3'b000) return (b30 && !src) ? 4'd6 : 4'd2;
            if (f3 == 3'b111) return 4'd0;
            if (f3 == 3'b110) return 4'd1;
        end
        return 4'd2;
    endfunction

    function automatic logic m_ill(input logic [1:0] op, input logic [2:0] f3);
        if (op == 2'b11) return 1'b1;
        if (op == 2'b10 && !(f3 == 3'b000 || f3 == 3'b111 || f3 == 3'b110)) return 1'b1;
        return 1'b0;
    endfunction

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [63:0] res;
        logic        bt;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   n_acc = 0;   // accepted ops since last reset
    int   n_ill = 0;   // accepted illegal ops since last reset

    always @(negedge clk) begin
        exp_t e;
        logic [3:0]  c;
        logic [63:0] r;
        if (reset) begin
            sb.delete();
            n_acc = 0;
            n_ill = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_val("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check_val("sb_result", result, e.res);
                    check_val("sb_branch", {63'd0, branchTaken}, {63'd0, e.bt});
                    check_val("sb_illegal", {63'd0, illegal}, {63'd0, e.ill});
                end
            end
            if (in_valid && in_ready) begin
                c     = m_ctrl(aluOp, funct3, funct7b30, aluSrc);
                r     = alu_f(rs1, aluSrc ? imm : rs2, c);
                e.res = r;
                e.bt  = branch && (r == 64'h0);
                e.ill = m_ill(aluOp, funct3);
                sb.push_back(e);
                n_acc++;
                if (e.ill) n_ill++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic b30,
                         input logic src, input logic br,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] im);
        aluOp = op; funct3 = f3; funct7b30 = b30; aluSrc = src; branch = br;
        rs1 = a; rs2 = b; imm = im;
        in_valid = 1'b1;
    endtask

    // Present a request and return #1 after the edge that accepts it.
    task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic b30,
                        input logic src, input logic br,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] im);
        logic ok;
        drive(op, f3, b30, src, br, a, b, im);
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) check_val("send_timeout", 64'd0, 64'd1);
        step();
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b1; out_ready = 1'b0;
        drive(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 64'd9, 64'd9, 64'd0); // ignored in reset
        repeat (3) step();
        check_val("rst_out_valid", {63'd0, out_valid}, 64'd0);
        reset = 1'b0; idle();
        check_val("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check_val("rst_aluControl", {60'd0, aluControl}, 64'd0);
        check_val("rst_aluX", aluX, 64'd0);
        check_val("rst_result", result, 64'd0);
        check_val("rst_issued", {32'd0, issued_cnt}, 64'd0);

        // Test 1: R-type ADD, 2-edge latency
        out_ready = 1'b1;
        send(2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 64'd5, 64'd7, 64'd0);
        check_val("t1_ctrl", {60'd0, aluControl}, 64'd2);
        check_val("t1_not_yet_valid", {63'd0, out_valid}, 64'd0);
        idle();
        step();
        check_val("t1_out_valid", {63'd0, out_valid}, 64'd1);
        check_val("t1_result", result, 64'd12);
        check_val("t1_illegal", {63'd0, illegal}, 64'd0);
        step();

        // Test 2: beq taken / not taken
        send(2'b01, 3'b000, 1'b0, 1'b0, 1'b1, 64'hDEAD, 64'hDEAD, 64'd0);
        check_val("t2_ctrl", {60'd0, aluControl}, 64'd6);
        idle();
        step();
        check_val("t2_result", result, 64'd0);
        check_val("t2_taken", {63'd0, branchTaken}, 64'd1);
        send(2'b01, 3'b000, 1'b0, 1'b0, 1'b1, 64'hDEAD, 64'd1, 64'd0);
        idle();
        step();
        check_val("t2_result_nt", result, 64'hDEAC);
        check_val("t2_not_taken", {63'd0, branchTaken}, 64'd0);
        step();

        // Test 3: AND then OR back-to-back
        send(2'b10, 3'b111, 1'b0, 1'b0, 1'b0, 64'hF0, 64'h3C, 64'd0);
        send(2'b10, 3'b110, 1'b0, 1'b0, 1'b0, 64'hF0, 64'h3C, 64'd0);
        check_val("t3_and_valid", {63'd0, out_valid}, 64'd1);
        check_val("t3_and_result", result, 64'h30);
        check_val("t3_or_ctrl", {60'd0, aluControl}, 64'd1);
        idle();
        step();
        check_val("t3_or_valid", {63'd0, out_valid}, 64'd1);
        check_val("t3_or_result", result, 64'hFC);
        step();
        check_val("t3_drained", {63'd0, out_valid}, 64'd0);
        check_val("t3_result_hold", result, 64'hFC);

        // Test 4: backpressure with three ops offered
        out_ready = 1'b0;
        send(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 64'd1, 64'd2, 64'd0);   // A: 3
        send(2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 64'd10, 64'd3, 64'd0);  // B: 7
        drive(2'b10, 3'b110, 1'b0, 1'b1, 1'b0, 64'd1, 64'd99, 64'd4); // C: 1|4 = 5
        for (int k = 0; k < 5; k++) begin
            check_val("t4_in_ready", {63'd0, in_ready}, 64'd0);
            check_val("t4_out_valid", {63'd0, out_valid}, 64'd1);
            check_val("t4_result_stable", result, 64'd3);
            check_val("t4_aluX_stable", aluX, 64'd10);
            check_val("t4_ctrl_stable", {60'd0, aluControl}, 64'd6);
            step();
        end
        out_ready = 1'b1;
        send(2'b10, 3'b110, 1'b0, 1'b1, 1'b0, 64'd1, 64'd99, 64'd4);
        check_val("t4_B_result", result, 64'd7);
        check_val("t4_C_aluY", aluY, 64'd4);
        idle();
        step();
        check_val("t4_C_result", result, 64'd5);
        step();
        check_val("t4_drained", {63'd0, out_valid}, 64'd0);
        check_val("t4_issued", {32'd0, issued_cnt}, 64'(n_acc));

        // Test 5: illegal encodings
        send(2'b10, 3'b001, 1'b0, 1'b0, 1'b0, 64'd5, 64'd7, 64'd0);
        check_val("t5_ctrl", {60'd0, aluControl}, 64'd2);
        check_val("t5_ill_cnt1", {32'd0, illegal_cnt}, 64'd1);
        idle();
        step();
        check_val("t5_illegal", {63'd0, illegal}, 64'd1);
        send(2'b11, 3'b000, 1'b0, 1'b0, 1'b0, 64'd2, 64'd3, 64'd0);
        check_val("t5_ctrl_op11", {60'd0, aluControl}, 64'd2);
        check_val("t5_ill_cnt2", {32'd0, illegal_cnt}, 64'd2);
        check_val("t5_ill_model", {32'd0, illegal_cnt}, 64'(n_ill));
        idle();
        step();
        check_val("t5_illegal2", {63'd0, illegal}, 64'd1);
        step();

        // Test 6: reset with both stages full
        out_ready = 1'b0;
        send(2'b00, 3'b000, 1'b0, 1'b0, 1'b1, 64'd4, 64'd4, 64'd0);
        send(2'b01, 3'b000, 1'b0, 1'b0, 1'b1, 64'd4, 64'd4, 64'd0);
        check_val("t6_full", {63'd0, in_ready}, 64'd0);
        reset = 1'b1;   // in_valid still high: must be ignored
        step();
        check_val("t6_out_valid", {63'd0, out_valid}, 64'd0);
        check_val("t6_in_ready", {63'd0, in_ready}, 64'd1);
        check_val("t6_issued", {32'd0, issued_cnt}, 64'd0);
        check_val("t6_ill_cnt", {32'd0, illegal_cnt}, 64'd0);
        check_val("t6_ctrl", {60'd0, aluControl}, 64'd0);
        check_val("t6_result", result, 64'd0);
        check_val("t6_taken", {63'd0, branchTaken}, 64'd0);
        idle();
        reset = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_val("t6_no_stale", {63'd0, out_valid}, 64'd0);
        end
        send(2'b00, 3'b000, 1'b0, 1'b1, 1'b0, 64'd100, 64'd0, 64'd23);
        check_val("t6_issued_restart", {32'd0, issued_cnt}, 64'd1);
        idle();
        step();
        check_val("t6_post_result", result, 64'd123);
        step();

        check_val("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_alu_issue_ctrl
`default_nettype wire
